// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM with byte-lane stores, extending loads and misalign flagging; define DMEM_CLEAR_EN to zero the RAM after reset
module dmem_responder #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_sl_type,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign
);
  localparam logic [3:0] LB = 4'b0001, LH = 4'b0010, LW = 4'b0011, LBU = 4'b0100, LHU = 4'b0101;
  localparam logic [3:0] SB = 4'b1000, SH = 4'b1001, SW = 4'b1010;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx, clr_idx;
  logic [1:0] lane, ld_lane;
  logic [3:0] be, ld_type;
  logic [31:0] wd, rd_word;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic is_b, is_h, is_w, mis, acc, st, ld, clr_we, unused_addr;
  assign idx = req_addr[DEPTH_LOG2+1:2];
  assign lane = req_addr[1:0];
  assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];
  assign is_b = req_sl_type == LB || req_sl_type == LBU || req_sl_type == SB;
  assign is_h = req_sl_type == LH || req_sl_type == LHU || req_sl_type == SH;
  assign is_w = req_sl_type == LW || req_sl_type == SW;
  assign mis = !(is_b || is_h || is_w) || (is_h && lane[0]) || (is_w && |lane);
  assign acc = req_valid && req_ready;
  assign st = acc && !mis && req_sl_type[3];
  assign ld = acc && !mis && !req_sl_type[3];
  assign be = is_w ? 4'hf : is_h ? (lane[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
  assign wd = is_w ? req_wdata : is_h ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
`ifdef DMEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  // after reset, sweep every word to zero before accepting requests
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      state <= &clr_idx ? READY : CLEAR;
    end
  end
  assign clr_we = rst_n && state == CLEAR;
  assign req_ready = rst_n && state == READY;
`else
  logic rdy;
  // ready from the first cycle after reset is released
  always_ff @(posedge clk) rdy <= rst_n;
  assign clr_we = 1'b0;
  assign clr_idx = '0;
  assign req_ready = rst_n && rdy;
`endif
  // RAM: clear sweep or lane-masked store; loads read the word at the accept edge
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_idx] <= '0;
    else if (st) for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    if (ld) rd_word <= mem[idx];
  end
  // response pulse one cycle after acceptance; ld_type 0 forces zero data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_misalign <= 1'b0;
      ld_type <= '0;
      ld_lane <= '0;
    end else begin
      rsp_valid <= acc;
      rsp_misalign <= acc && mis;
      ld_type <= ld ? req_sl_type : 4'b0000;
      ld_lane <= lane;
    end
  end
  assign byte_sel = rd_word[{ld_lane, 3'b000} +: 8];
  assign half_sel = ld_lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign rsp_rdata = ld_type == LB  ? {{24{byte_sel[7]}}, byte_sel} :
                     ld_type == LBU ? {24'b0, byte_sel} :
                     ld_type == LH  ? {{16{half_sel[15]}}, half_sel} :
                     ld_type == LHU ? {16'b0, half_sel} :
                     ld_type == LW  ? rd_word : 32'b0;
endmodule
